pwm_decoder: RTL and testbench

Measures the duty cycle of an incoming PWM signal and reports it as a WIDTH-bit level word. It is the receive-side counterpart of the team's PWM generator: when driven by that generator with the same strobe and WIDTH, it recovers the generator's level input exactly. It is used for loopback self-test of the RGB mixer outputs and for reading external PWM sources into the mixer.

---
 rtl/pwm_decoder.sv | 97 +++++++++
 tb/tb_pwm_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM duty-cycle decoder: counts active samples over 2^WIDTH strobes
module pwm_decoder #(
    parameter int WIDTH  = 8,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic             level_valid,
    output logic             full,
    output logic             locked
);

    localparam logic [WIDTH-1:0] WIN_LAST = '1;
    localparam logic [WIDTH:0]   FULL_CNT = {1'b1, {WIDTH{1'b0}}};

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [WIDTH:0]   hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             level_valid_q, level_valid_d;
    logic             full_q, full_d;
    logic             locked_q, locked_d;
    logic [WIDTH:0]   prev_total_q, prev_total_d;
    logic             have_prev_q, have_prev_d;

    logic             sample;
    logic [WIDTH:0]   total;

    always_comb begin
        sync1_d       = pwm_in;
        sync2_d       = sync1_q;
        win_cnt_d     = win_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        level_d       = level_q;
        level_valid_d = 1'b0;
        full_d        = full_q;
        locked_d      = locked_q;
        prev_total_d  = prev_total_q;
        have_prev_d   = have_prev_q;

        sample = sync2_q ^ INVERT;
        // hi_cnt never exceeds 2^WIDTH-1 before the closing sample, so total fits WIDTH+1 bits
        total  = hi_cnt_q + {{WIDTH{1'b0}}, sample};

        if (strobe) begin
            if (win_cnt_q != WIN_LAST) begin
                win_cnt_d = win_cnt_q + WIDTH'(1);
                hi_cnt_d  = total;
            end else begin
                level_d       = (total == FULL_CNT) ? '1 : total[WIDTH-1:0];
                full_d        = (total == FULL_CNT);
                level_valid_d = 1'b1;
                locked_d      = have_prev_q && (total == prev_total_q);
                prev_total_d  = total;
                have_prev_d   = 1'b1;
                win_cnt_d     = '0;
                hi_cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            win_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            full_q        <= 1'b0;
            locked_q      <= 1'b0;
            prev_total_q  <= '0;
            have_prev_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            win_cnt_q     <= win_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            full_q        <= full_d;
            locked_q      <= locked_d;
            prev_total_q  <= prev_total_d;
            have_prev_q   <= have_prev_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign full        = full_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed bench for pwm_decoder driven by a generator-style stimulus
module tb_pwm_decoder;

    logic       clk;
    logic       reset;
    logic       strobe;
    logic       pwm_in;
    logic [7:0] level_a, level_b;
    logic       valid_a, valid_b;
    logic       full_a, full_b;
    logic       locked_a, locked_b;

    int         n_pass;
    int         n_total;
    logic [7:0] gen_cnt;
    int         gen_level;

    pwm_decoder #(.WIDTH(8), .INVERT(1'b0)) u_dec (
        .clk(clk), .reset(reset), .strobe(strobe), .pwm_in(pwm_in),
        .level(level_a), .level_valid(valid_a), .full(full_a), .locked(locked_a)
    );

    pwm_decoder #(.WIDTH(8), .INVERT(1'b1)) u_inv (
        .clk(clk), .reset(reset), .strobe(strobe), .pwm_in(pwm_in),
        .level(level_b), .level_valid(valid_b), .full(full_b), .locked(locked_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clk: pwm_in follows the generator (high while gen_cnt < gen_level), which steps on strobe.
    task automatic tick(input logic s, input logic r);
        @(negedge clk);
        strobe = s;
        reset  = r;
        pwm_in = (int'(gen_cnt) < gen_level);
        @(posedge clk);
        if (s) gen_cnt = gen_cnt + 8'd1;
        #1;
    endtask

    task automatic run(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int j = 1; j < gap; j++) tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
    endtask

    task automatic do_reset(input logic [7:0] phase, input int lvl);
        gen_cnt   = phase;
        gen_level = lvl;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        clk = 0; reset = 1; strobe = 0; pwm_in = 0;
        n_pass = 0; n_total = 0; gen_cnt = 0; gen_level = 0;

        // Reset state
        do_reset(8'd100, 64);
        chk("rst_level", level_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_locked", locked_a, 0);

        // Duty 0x40, strobe every clk
        run(255, 1);
        chk("d40_valid_early", valid_a, 0);
        run(1, 1);
        chk("d40_w1_valid", valid_a, 1);
        chk("d40_w1_level", level_a, 8'h40);
        chk("d40_w1_full", full_a, 0);
        chk("d40_w1_locked", locked_a, 0);
        run(1, 1);
        chk("d40_valid_drop", valid_a, 0);
        run(255, 1);
        chk("d40_w2_valid", valid_a, 1);
        chk("d40_w2_level", level_a, 8'h40);
        chk("d40_w2_locked", locked_a, 1);

        // Constant high
        do_reset(8'd0, 256);
        run(256, 1);
        chk("hi_w1_level", level_a, 8'hFF);
        chk("hi_w1_full", full_a, 1);
        chk("hi_w1_locked", locked_a, 0);
        run(256, 1);
        chk("hi_w2_level", level_a, 8'hFF);
        chk("hi_w2_full", full_a, 1);
        chk("hi_w2_locked", locked_a, 1);

        // Constant low
        do_reset(8'd0, 0);
        run(256, 1);
        chk("lo_w1_level", level_a, 8'h00);
        chk("lo_w1_full", full_a, 0);
        run(256, 1);
        chk("lo_w2_level", level_a, 8'h00);
        chk("lo_w2_locked", locked_a, 1);

        // Duty 255/256 then constant high: 255 and 256 must not lock
        do_reset(8'd0, 255);
        run(512, 1);
        chk("d255_level", level_a, 8'hFF);
        chk("d255_full", full_a, 0);
        chk("d255_locked", locked_a, 0);
        gen_level = 256;
        run(512, 1);
        chk("d255hi_level", level_a, 8'hFF);
        chk("d255hi_full", full_a, 1);
        chk("d255hi_locked", locked_a, 0);

        // Duty change 0x80 -> 0x10 in the middle of window 4
        do_reset(8'd200, 128);
        run(256, 1);
        chk("chg_w1_level", level_a, 8'h80);
        run(512, 1);
        chk("chg_w3_locked", locked_a, 1);
        run(100, 1);
        gen_level = 16;
        run(156, 1);
        chk("chg_w4_level", level_a, 8'h2C);
        chk("chg_w4_locked", locked_a, 0);
        run(256, 1);
        chk("chg_w5_level", level_a, 8'h10);
        chk("chg_w5_locked", locked_a, 0);
        run(256, 1);
        chk("chg_w6_level", level_a, 8'h10);
        chk("chg_w6_locked", locked_a, 1);

        // Sparse strobe, every 4 clk, level 0xC3
        do_reset(8'd220, 195);
        run(256, 4);
        chk("sp_w1_valid", valid_a, 1);
        chk("sp_w1_level", level_a, 8'hC3);
        tick(1'b0, 1'b0);
        chk("sp_valid_width", valid_a, 0);
        run(256, 4);
        chk("sp_w2_level", level_a, 8'hC3);
        chk("sp_w2_locked", locked_a, 1);

        // Inverted instance with 0x20-high input
        do_reset(8'd100, 32);
        run(256, 1);
        chk("inv_plain_level", level_a, 8'h20);
        chk("inv_level", level_b, 8'hE0);
        chk("inv_full", full_b, 0);

        // Reset at strobe 100 of window 2
        do_reset(8'd100, 64);
        run(256, 1);
        run(99, 1);
        tick(1'b1, 1'b1);
        chk("mid_rst_level", level_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_full", full_a, 0);
        chk("mid_rst_locked", locked_a, 0);
        run(255, 1);
        chk("mid_valid_early", valid_a, 0);
        run(1, 1);
        chk("mid_valid", valid_a, 1);
        chk("mid_level", level_a, 8'h40);
        chk("mid_locked", locked_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
